// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit for RV64M MUL, MULHU, DIVU, REMU.
// Uses one radix-2 step per cycle for a fixed WIDTH-cycle latency, then pulses RegWrite once.
module mul_div_unit #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] ReadData1,
    input  logic [WIDTH-1:0] ReadData2,
    input  logic [4:0]       RdIn,
    output logic             Busy,
    output logic [WIDTH-1:0] WriteData,
    output logic [4:0]       Rd,
    output logic             RegWrite
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t            state;
    logic [CW-1:0]     count;
    logic [1:0]        opReg;
    logic [4:0]        rdReg;
    logic [WIDTH-1:0]  opA, opB;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]  rem;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] accMul;
    logic [WIDTH:0]     divShift, divTrial;
    logic               divGe;
    logic [WIDTH-1:0]   remNext, qNext;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   result;

    // Multiply: acc = {partial, multiplier}; the multiplier is consumed from the LSB as the sum shifts in.
    // Divide: acc low half holds dividend bits that become quotient bits.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opA} : '0);
        accMul   = {mulSum, acc[WIDTH-1:1]};
        divShift = {rem, acc[WIDTH-1]};
        divTrial = divShift - {1'b0, opB};
        divGe    = ~divTrial[WIDTH];
        remNext  = divGe ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
        qNext    = {acc[WIDTH-2:0], divGe};
        accNext  = opReg[1] ? {acc[2*WIDTH-1:WIDTH], qNext} : accMul;
        case (opReg)
            2'b00:   result = accMul[WIDTH-1:0];
            2'b01:   result = accMul[2*WIDTH-1:WIDTH];
            2'b10:   result = qNext;
            default: result = remNext;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            count     <= '0;
            opReg     <= '0;
            rdReg     <= '0;
            opA       <= '0;
            opB       <= '0;
            acc       <= '0;
            rem       <= '0;
            Busy      <= 1'b0;
            WriteData <= '0;
            Rd        <= '0;
            RegWrite  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    RegWrite <= 1'b0;
                    if (Start) begin
                        opA   <= ReadData1;
                        opB   <= ReadData2;
                        opReg <= Op;
                        rdReg <= RdIn;
                        count <= '0;
                        rem   <= '0;
                        acc   <= Op[1] ? {{WIDTH{1'b0}}, ReadData1} : {{WIDTH{1'b0}}, ReadData2};
                        Busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    rem   <= remNext;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        WriteData <= result;
                        Rd        <= rdReg;
                        RegWrite  <= (rdReg != 5'd0);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    RegWrite <= 1'b0;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the stimulus queues expected write-backs, and a monitor checks each RegWrite pulse.
module tb_mul_div_unit;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] ReadData1, ReadData2;
    logic [4:0]  RdIn;
    logic        Busy;
    logic [63:0] WriteData;
    logic [4:0]  Rd;
    logic        RegWrite;

    int checks = 0;
    int fails  = 0;
    logic [68:0] sb[$];
    logic prevRw = 1'b0;

    mul_div_unit #(.WIDTH(64)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .RdIn(RdIn),
        .Busy(Busy), .WriteData(WriteData), .Rd(Rd), .RegWrite(RegWrite)
    );

    always #5 Clk = ~Clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] refModel(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (op)
            2'b00:   return p[63:0];
            2'b01:   return p[127:64];
            2'b10:   return (b == 64'd0) ? {64{1'b1}} : a / b;
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    // Monitor: each write pulse must match the oldest queued expectation and must last one cycle.
    always @(negedge Clk) begin
        if (RegWrite === 1'b1) begin
            check("single_pulse", {63'd0, prevRw}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_regwrite", 64'd1, 64'd0);
            end else begin
                logic [68:0] e;
                e = sb.pop_front();
                check("wb_data", WriteData, e[63:0]);
                check("wb_rd", {59'd0, Rd}, {59'd0, e[68:64]});
            end
        end
        prevRw <= (RegWrite === 1'b1);
    end

    task automatic runOp(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int injectAt, input int resetAt);
        logic [63:0] exp;
        bit early, busyLow;
        exp = refModel(op, a, b);
        @(negedge Clk);
        Start = 1'b1; Op = op; ReadData1 = a; ReadData2 = b; RdIn = rd;
        if (rd != 5'd0 && resetAt == 0) sb.push_back({rd, exp});
        @(posedge Clk); #1;
        Start = 1'b0;
        ReadData1 = {$urandom, $urandom}; ReadData2 = {$urandom, $urandom};
        Op = ~op; RdIn = rd + 5'd1;
        early = 0; busyLow = 0;
        for (int k = 1; k <= 64; k++) begin
            if (Busy !== 1'b1) busyLow = 1;
            if (RegWrite !== 1'b0) early = 1;
            Start = (k == injectAt);
            if (resetAt != 0 && k == resetAt) begin
                Reset = 1'b0; #1;
                check("rst_busy", {63'd0, Busy}, 64'd0);
                check("rst_wdata", WriteData, 64'd0);
                check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
                repeat (3) @(posedge Clk);
                @(negedge Clk); Reset = 1'b1;
                repeat (70) @(posedge Clk);
                #1;
                check("rst_idle_busy", {63'd0, Busy}, 64'd0);
                return;
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        check("no_early_regwrite", {63'd0, early}, 64'd0);
        check("busy_t0_t64", {63'd0, busyLow}, 64'd0);
        check("regwrite_t64", {63'd0, RegWrite}, {63'd0, rd != 5'd0});
        if (rd == 5'd0) begin
            check("rd0_wdata", WriteData, exp);
            check("rd0_rd", {59'd0, Rd}, 64'd0);
        end
        @(posedge Clk); #1;
        check("t65_regwrite", {63'd0, RegWrite}, 64'd0);
        check("t65_busy", {63'd0, Busy}, 64'd0);
        if (injectAt != 0) begin
            repeat (2) @(posedge Clk); #1;
            check("inject_no_restart", {63'd0, Busy}, 64'd0);
        end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Op = 2'b00; ReadData1 = '0; ReadData2 = '0; RdIn = '0;
        repeat (3) @(posedge Clk); #1;
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_regwrite", {63'd0, RegWrite}, 64'd0);
        check("reset_wdata", WriteData, 64'd0);
        check("reset_rd", {59'd0, Rd}, 64'd0);
        @(negedge Clk); Reset = 1'b1;

        runOp(2'b00, 64'd7, 64'd6, 5'd5, 0, 0);
        runOp(2'b01, {64{1'b1}}, {64{1'b1}}, 5'd1, 0, 0);
        runOp(2'b00, {64{1'b1}}, {64{1'b1}}, 5'd2, 0, 0);
        runOp(2'b10, 64'd100, 64'd7, 5'd3, 0, 0);
        runOp(2'b11, 64'd100, 64'd7, 5'd4, 0, 0);
        runOp(2'b10, 64'd100, 64'd0, 5'd6, 0, 0);
        runOp(2'b11, 64'd100, 64'd0, 5'd7, 0, 0);
        runOp(2'b00, 64'd9, 64'd11, 5'd8, 10, 0);
        runOp(2'b01, 64'hDEAD_BEEF_1234_5678, 64'hCAFE_F00D_8765_4321, 5'd9, 0, 30);
        runOp(2'b00, 64'd3, 64'd4, 5'd10, 0, 0);
        runOp(2'b00, 64'd5, 64'd5, 5'd0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [63:0] a, b;
            logic [1:0] op;
            logic [4:0] rd;
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'($urandom_range(0, 15));
                1:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            rd = (i % 5 == 4) ? 5'd0 : 5'($urandom_range(1, 31));
            runOp(op, a, b, rd, 0, 0);
        end

        repeat (4) @(posedge Clk); #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

- Iterative 64-bit RV64M execute unit supporting MUL, MULHU, DIVU and REMU.
- Sits directly downstream of `registerFile`: takes the two register read ports as operands and drives the write port (`WriteData`, `Rd`, `RegWrite`) back into the file.
- One operation at a time: a Start/Busy handshake, then a fixed 64-cycle radix-2 iteration, then a single-cycle write-back pulse.

## Interface
- WIDTH, 64, operand/result width; counter and state sized from it.
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled only in IDLE
- Op  in  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU
- ReadData1  in  WIDTH  operand A (rs1 / dividend)
- ReadData2  in  WIDTH  operand B (rs2 / divisor)
- RdIn  in  5  destination register index for this operation
- Busy  out  1  high whenever state is not IDLE
- WriteData  out  WIDTH  result; holds last result until the next write-back
- Rd  out  5  destination index accompanying WriteData
- RegWrite  out  1  one-cycle write-enable pulse to the register file

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - Start=1 at an edge: latch ReadData1, ReadData2, Op and RdIn; clear the iteration counter; go to RUN.
  - Start=0: stay in IDLE.
- **RUN**
  - Each edge performs one iteration and increments the counter.
  - On the edge with counter==WIDTH-1: load WriteData and Rd, assert RegWrite, go to DONE.
- **DONE**: next edge deasserts RegWrite and returns to IDLE.
- **Multiply**: shift-add into a 2*WIDTH accumulator, one multiplier bit per iteration.
  - MUL returns bits [WIDTH-1:0].
  - MULHU returns bits [2*WIDTH-1:WIDTH].
  - Operands are unsigned; overflow discarded beyond 2*WIDTH.
- **Divide**: restoring division, one quotient bit per iteration.
  - WIDTH-bit remainder with one extra bit for the trial subtract.
  - DIVU returns the quotient; REMU returns the remainder.
- **Divide by zero**: no special path. Restoring division naturally yields quotient all-ones and remainder = dividend, which matches RISC-V.
- **Rd==0**: RegWrite stays 0 for the whole operation. WriteData and Rd still update; Busy timing is unchanged.
- **Start while Busy** (RUN or DONE): ignored. Operands are not re-latched and no queueing occurs.
- **Input stability**: input changes after the latch edge have no effect on the result.

## Timing
- Reset values: state IDLE, Busy 0, RegWrite 0, WriteData 0, Rd 0, counter 0.
- Start sampled at edge t0:
  - Busy rises after t0.
  - Iterations occur on edges t1..t64.
  - RegWrite is high from t64 to t65, with WriteData/Rd valid in the same cycle.
  - At t65 RegWrite falls and Busy falls.
- Earliest next accepted Start is edge t66, when the state is IDLE again.
- Latency is fixed: result visible 64 cycles after the Start edge; 66-cycle initiation interval.
- Latency does not depend on Op or operand values.
- **Reset mid-operation** (any state): immediate return to IDLE with all outputs at reset values.
  - The in-flight result is discarded; no RegWrite pulse is produced.
  - The first Start after Reset deasserts behaves normally.
- **Output registering**: all outputs are registered. WriteData/Rd change only on the DONE-entry edge or on reset.

## Test plan
- MUL, A=7, B=6, RdIn=5, Start at t0 -> RegWrite=1 exactly in the cycle after edge t64, with WriteData=42 and Rd=5. Busy is high t0..t65.
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> WriteData=0xFFFF_FFFF_FFFF_FFFE. Then MUL with the same operands -> WriteData=0x0000_0000_0000_0001.
- DIVU 100/7 -> WriteData=14. Then REMU 100/7 -> WriteData=2. Each arrives with a single RegWrite pulse.
- DIVU 100/0 -> WriteData=0xFFFF_FFFF_FFFF_FFFF. REMU 100/0 -> WriteData=100.
- Start pulsed again at iteration 10 with different operands -> ignored; the original result is delivered on schedule. Reset low at iteration 30 -> Busy=0 and WriteData=0 immediately, and no RegWrite. A fresh MUL 3*4 afterwards -> 12.
- RdIn=0, MUL 5*5 -> RegWrite never asserts; Busy falls after t65. WriteData=25, Rd=0.
